// File: rtl/pc_unit.sv
// Program counter stage feeding address_bus: increment, bus/latch/vector loads,
// and relative branches with a one-cycle high-byte fix-up on page crossing.
module pc_unit #(
  parameter logic [15:0] RESET_PC = 16'hFFFC
) (
  input  logic       fclk,
  input  logic       resb,
  input  logic       cyc_en,
  input  logic       rdy,
  input  logic [2:0] pc_op,
  input  logic       branch_take,
  input  logic [7:0] branch_offset,
  input  logic [1:0] vec_sel,
  input  logic [7:0] ab_pch,
  input  logic [7:0] ab_pcl,
  input  logic [7:0] dl_a,
  input  logic [7:0] dl_b,
  output logic [7:0] PCH_in,
  output logic [7:0] PCL_in,
  output logic       busy,
  output logic       page_cross
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FIXUP = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_INC    = 3'b001,
    OP_LDBUS  = 3'b010,
    OP_LDLAT  = 3'b011,
    OP_BRANCH = 3'b100,
    OP_VECTOR = 3'b101
  } pc_op_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_pch;
  logic [7:0] r_pcl;
  logic [7:0] w_pch_nxt;
  logic [7:0] w_pcl_nxt;
  logic       r_dir_back;
  logic       w_dir_back_nxt;
  logic       r_page_cross;
  logic       w_page_cross_nxt;
  logic       w_en;
  logic [8:0] w_sum;
  logic       w_cross;
  logic [7:0] w_vec_lo;

  assign w_en  = cyc_en & rdy;
  assign w_sum = {1'b0, r_pcl} + {1'b0, branch_offset};
  // A backward offset is +256-|d| in 9 bits, so no carry means we left the page.
  assign w_cross = branch_offset[7] ? ~w_sum[8] : w_sum[8];

  always_comb begin
    case (vec_sel)
      2'b00:   w_vec_lo = 8'hFA;
      2'b01:   w_vec_lo = 8'hFC;
      default: w_vec_lo = 8'hFE;
    endcase
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pch_nxt        = r_pch;
    w_pcl_nxt        = r_pcl;
    w_dir_back_nxt   = r_dir_back;
    w_page_cross_nxt = 1'b0;
    if (w_en) begin
      case (r_state)
        S_IDLE: begin
          case (pc_op)
            OP_INC:    {w_pch_nxt, w_pcl_nxt} = {r_pch, r_pcl} + 16'd1;
            OP_LDBUS:  {w_pch_nxt, w_pcl_nxt} = {ab_pch, ab_pcl};
            OP_LDLAT:  {w_pch_nxt, w_pcl_nxt} = {dl_a, dl_b};
            OP_VECTOR: {w_pch_nxt, w_pcl_nxt} = {8'hFF, w_vec_lo};
            OP_BRANCH: begin
              if (branch_take) begin
                w_pcl_nxt = w_sum[7:0];
                if (w_cross) begin
                  w_dir_back_nxt   = branch_offset[7];
                  w_state_nxt      = S_FIXUP;
                  w_page_cross_nxt = 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
        S_FIXUP: begin
          w_pch_nxt   = r_dir_back ? r_pch - 8'd1 : r_pch + 8'd1;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge fclk) begin
    if (!resb) begin
      r_state      <= S_IDLE;
      r_pch        <= RESET_PC[15:8];
      r_pcl        <= RESET_PC[7:0];
      r_dir_back   <= 1'b0;
      r_page_cross <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pch        <= w_pch_nxt;
      r_pcl        <= w_pcl_nxt;
      r_dir_back   <= w_dir_back_nxt;
      r_page_cross <= w_page_cross_nxt;
    end
  end

  assign PCH_in     = r_pch;
  assign PCL_in     = r_pcl;
  assign busy       = (r_state == S_FIXUP);
  assign page_cross = r_page_cross;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with hand-computed expected PC values.
module tb_pc_unit;

  logic       fclk;
  logic       resb;
  logic       cyc_en;
  logic       rdy;
  logic [2:0] pc_op;
  logic       branch_take;
  logic [7:0] branch_offset;
  logic [1:0] vec_sel;
  logic [7:0] ab_pch;
  logic [7:0] ab_pcl;
  logic [7:0] dl_a;
  logic [7:0] dl_b;
  logic [7:0] PCH_in;
  logic [7:0] PCL_in;
  logic       busy;
  logic       page_cross;

  int unsigned n_checks;
  int unsigned n_errors;

  pc_unit #(.RESET_PC(16'hFFFC)) dut (
    .fclk(fclk), .resb(resb), .cyc_en(cyc_en), .rdy(rdy),
    .pc_op(pc_op), .branch_take(branch_take), .branch_offset(branch_offset),
    .vec_sel(vec_sel), .ab_pch(ab_pch), .ab_pcl(ab_pcl),
    .dl_a(dl_a), .dl_b(dl_b), .PCH_in(PCH_in), .PCL_in(PCL_in),
    .busy(busy), .page_cross(page_cross)
  );

  initial begin
    fclk = 1'b0;
    forever #5 fclk = ~fclk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] op);
    pc_op = op;
    tick();
  endtask

  task automatic load_pc(input logic [15:0] v);
    dl_a = v[15:8];
    dl_b = v[7:0];
    do_op(3'b011);
  endtask

  task automatic branch(input logic take, input logic [7:0] off);
    branch_take   = take;
    branch_offset = off;
    do_op(3'b100);
    branch_take   = 1'b0;
  endtask

  // Taken branch followed by one fix-up edge, checking both intermediate and final PC.
  task automatic branch_cross(input string tag, input logic [15:0] start,
                              input logic [7:0] off, input logic [15:0] mid,
                              input logic [15:0] fin);
    load_pc(start);
    branch(1'b1, off);
    check({tag, "_mid"}, {PCH_in, PCL_in}, mid);
    check({tag, "_busy"}, {15'd0, busy}, 16'd1);
    check({tag, "_pcross"}, {15'd0, page_cross}, 16'd1);
    do_op(3'b000);
    check({tag, "_fin"}, {PCH_in, PCL_in}, fin);
    check({tag, "_busy_clr"}, {15'd0, busy}, 16'd0);
    check({tag, "_pcross_clr"}, {15'd0, page_cross}, 16'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    resb = 1'b0; cyc_en = 1'b1; rdy = 1'b1; pc_op = 3'b000;
    branch_take = 1'b0; branch_offset = 8'h00; vec_sel = 2'b00;
    ab_pch = 8'h00; ab_pcl = 8'h00; dl_a = 8'h00; dl_b = 8'h00;

    tick(); tick();
    check("rst_pc", {PCH_in, PCL_in}, 16'hFFFC);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_pcross", {15'd0, page_cross}, 16'd0);
    resb = 1'b1;

    do_op(3'b001); check("inc1", {PCH_in, PCL_in}, 16'hFFFD);
    do_op(3'b001); check("inc2", {PCH_in, PCL_in}, 16'hFFFE);
    do_op(3'b001); check("inc3", {PCH_in, PCL_in}, 16'hFFFF);
    do_op(3'b001); check("inc_wrap", {PCH_in, PCL_in}, 16'h0000);

    load_pc(16'h1234); check("ld_lat", {PCH_in, PCL_in}, 16'h1234);
    ab_pch = 8'hAB; ab_pcl = 8'hCD;
    do_op(3'b010); check("ld_bus", {PCH_in, PCL_in}, 16'hABCD);
    vec_sel = 2'b00; do_op(3'b101); check("vec_nmi", {PCH_in, PCL_in}, 16'hFFFA);
    vec_sel = 2'b01; do_op(3'b101); check("vec_res", {PCH_in, PCL_in}, 16'hFFFC);
    vec_sel = 2'b10; do_op(3'b101); check("vec_irq", {PCH_in, PCL_in}, 16'hFFFE);
    load_pc(16'h1234);
    vec_sel = 2'b11; do_op(3'b101); check("vec_11", {PCH_in, PCL_in}, 16'hFFFE);

    rdy = 1'b0;
    load_pc(16'h5678); check("rdy_hold", {PCH_in, PCL_in}, 16'hFFFE);
    rdy = 1'b1;
    cyc_en = 1'b0;
    load_pc(16'h5678); check("cyc_hold", {PCH_in, PCL_in}, 16'hFFFE);
    cyc_en = 1'b1;

    do_op(3'b110); check("op110_hold", {PCH_in, PCL_in}, 16'hFFFE);
    do_op(3'b111); check("op111_hold", {PCH_in, PCL_in}, 16'hFFFE);
    check("op111_busy", {15'd0, busy}, 16'd0);

    load_pc(16'h10F0);
    branch(1'b1, 8'h08);
    check("br_nocross", {PCH_in, PCL_in}, 16'h10F8);
    check("br_nocross_busy", {15'd0, busy}, 16'd0);
    check("br_nocross_pcross", {15'd0, page_cross}, 16'd0);
    branch(1'b0, 8'h20); check("br_untaken", {PCH_in, PCL_in}, 16'h10F8);
    check("br_untaken_busy", {15'd0, busy}, 16'd0);
    branch(1'b1, 8'h00); check("br_zero", {PCH_in, PCL_in}, 16'h10F8);
    check("br_zero_busy", {15'd0, busy}, 16'd0);

    branch_cross("fwd", 16'h10F0, 8'h20, 16'h1010, 16'h1110);
    branch_cross("bwd", 16'h1005, 8'hF0, 16'h10F5, 16'h0FF5);
    branch_cross("fwd_wrap", 16'hFFF0, 8'h20, 16'hFF10, 16'h0010);
    branch_cross("bwd_wrap", 16'h0005, 8'h80, 16'h0085, 16'hFF85);

    load_pc(16'h10F0);
    branch(1'b1, 8'h20);
    check("stall_enter", {PCH_in, PCL_in}, 16'h1010);
    check("stall_pcross", {15'd0, page_cross}, 16'd1);
    cyc_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_op(3'b001);
      check("stall_pc", {PCH_in, PCL_in}, 16'h1010);
      check("stall_busy", {15'd0, busy}, 16'd1);
      check("stall_pcross_clr", {15'd0, page_cross}, 16'd0);
    end
    cyc_en = 1'b1;
    do_op(3'b001);
    check("stall_fix", {PCH_in, PCL_in}, 16'h1110);
    check("stall_fix_busy", {15'd0, busy}, 16'd0);
    do_op(3'b001);
    check("stall_after", {PCH_in, PCL_in}, 16'h1111);

    load_pc(16'h10F0);
    branch(1'b1, 8'h20);
    check("rstfix_busy", {15'd0, busy}, 16'd1);
    resb = 1'b0;
    do_op(3'b000);
    check("rstfix_pc", {PCH_in, PCL_in}, 16'hFFFC);
    check("rstfix_busy_clr", {15'd0, busy}, 16'd0);
    check("rstfix_pcross", {15'd0, page_cross}, 16'd0);
    resb = 1'b1;
    do_op(3'b001);
    check("rstfix_inc", {PCH_in, PCL_in}, 16'hFFFD);
    check("rstfix_inc_busy", {15'd0, busy}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
